hello_world_button_pio: RTL and testbench
=========================================

Name: hello_world_button_pio

Overview:
- Avalon-MM slave parallel *input* port with edge capture and interrupt. Input-direction counterpart of the LED output PIO.
- Samples asynchronous devkit push-buttons, synchronises them and optionally debounces them.
- Latches per-bit edge events and raises a level interrupt to the Nios II processor.
- Sits on the same system interconnect as the LED PIO and uses the same 2-bit word address, 32-bit data convention.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 1, captured edge: 0 = rising, 1 = falling, 2 = any.
- IN_RESET_VAL, all-ones (WIDTH bits), reset value of synchroniser, filtered and previous-value registers. Buttons are active-low, so idle reads 1.
- DEBOUNCE_CYCLES, 16, stable cycles required before the filtered value changes. Used only with HELLO_BTN_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous button inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- **Reset (reset_n = 0, asynchronous):**
  - sync stages, filtered value and prev value = IN_RESET_VAL.
  - edge_capture = 0, irq_mask = 0, readdata = 0, irq = 0.
- **Synchroniser:** 2 flops per bit, so sync_in lags in_port by 2 clk.
- **Filtered value:** filt = sync_in (no debounce). With debounce see Optional Feature.
- **Edge detect:** prev <= filt every cycle. Per bit:
  - rise = filt & ~prev
  - fall = ~filt & prev
  - evt = rise, fall or (rise | fall), selected by EDGE_TYPE.
- **Register map (word address):**
  - 0 DATA, RO: filt, zero-extended. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK, RW: bits [WIDTH-1:0]. Upper bits read 0.
  - 3 EDGE_CAPTURE, RO plus write-1-to-clear per bit.
- **Write:** occurs when chipselect & ~write_n. Takes effect on the next clk edge. Zero wait states.
- **Read latency = 1:**
  - readdata is registered from the address/chipselect sampled when chipselect & ~read_n.
  - readdata holds its previous value when no read is in progress.
- **edge_capture[i] next state:**
  - evt[i] = 1 → set (event wins over a simultaneous clear).
  - else W1C write to address 3 with writedata[i] = 1 → clear.
  - else hold.
- **Reads have no side effects.** Reading EDGE_CAPTURE does not clear it.
- **irq** = |(edge_capture & irq_mask). Combinational from registers, so it follows mask writes on the cycle after the write edge. irq stays high until software clears the bit or masks it.
- **Input latency:** in_port edge → edge_capture set is 3 clk (2 sync + 1 detect), without debounce.
- **Reset mid-operation:** captured events are lost. No edge is reported for an input that already equals IN_RESET_VAL.

Optional Feature:
- Macro: HELLO_BTN_DEBOUNCE_EN.
- **Defined:**
  - One counter per bit, width clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0, and also clears whenever sync_in[i] == filt[i].
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, filt[i] <= sync_in[i] and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES clk is ignored.
  - Edge latency becomes 2 + DEBOUNCE_CYCLES + 1 clk.
- **Undefined:** no counters. filt = sync_in. DEBOUNCE_CYCLES is unused.

Test Plan:
- **Reset defaults:** hold in_port = 4'hF through reset, then read addresses 0, 2, 3 → readdata 0x0000000F, 0x0, 0x0 (each on the cycle after the read); irq = 0 throughout.
- **Falling-edge capture:** EDGE_TYPE = 1. Drive in_port[2] 1→0. edge_capture = 0x4 exactly 3 clk later; irq stays 0 because the mask is 0.
- **Mask, IRQ and clear:** write 0x4 to address 2 → irq = 1 next cycle. Write 0x4 to address 3 → edge_capture = 0 and irq = 0 next cycle. Writing 0x0 to address 3 instead leaves it set.
- **Clear/event collision:** write 0x1 to address 3 on the same cycle evt[0] fires → edge_capture[0] stays 1.
- **Reads are side-effect free:** write to address 0 with 0xFFFFFFFF → DATA is unchanged. Back-to-back reads of address 3 both return 0x4 (no clear-on-read).
- **Debounce (HELLO_BTN_DEBOUNCE_EN, DEBOUNCE_CYCLES = 16):**
  - 10-cycle low pulse on in_port[0] → no capture.
  - 20-cycle low pulse on in_port[0] → edge_capture[0] = 1 at 19 clk after the falling input.

Source files
------------

// File: rtl/hello_world_button_pio.sv
// Avalon-MM button input PIO: 2-flop sync, edge capture, masked level irq.
// Define HELLO_BTN_DEBOUNCE_EN to add per-bit debounce counters.
module hello_world_button_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IN_RESET_VAL    = {WIDTH{1'b1}},
    parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign rd_en     = chipselect & ~read_n;
    assign unused_wd = ^writedata;

`ifdef HELLO_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          filt_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                filt_q <= IN_RESET_VAL[i];
            end else if (sync2_q[i] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q  <= '0;
                filt_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign filt[i] = filt_q;
    end
`else
    localparam int unused_dc = DEBOUNCE_CYCLES;

    assign filt = sync2_q;
`endif

    always_comb begin
        rise = filt & ~prev_q;
        fall = ~filt & prev_q;
        evt  = rise | fall;
        case (EDGE_TYPE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase
    end

    // A new event beats a same-cycle write-1-to-clear.
    always_comb begin
        edge_d = edge_q;
        mask_d = mask_q;
        if (wr_en && address == 2'd3) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        edge_d = edge_d | evt;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (address)
                2'd0:    rdata_d = 32'(filt);
                2'd2:    rdata_d = 32'(mask_q);
                2'd3:    rdata_d = 32'(edge_q);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IN_RESET_VAL;
            sync2_q <= IN_RESET_VAL;
            prev_q  <= IN_RESET_VAL;
            edge_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= filt;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_hello_world_button_pio.sv
// Self-checking bench for hello_world_button_pio (falling-edge build).
// Read results go through an expected-value queue.
module tb_hello_world_button_pio;

    localparam int W = 4;
`ifdef HELLO_BTN_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read_n = 1'b1;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '1;
    logic [31:0]   readdata;
    logic          irq;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   d;
    logic [31:0]   e;

    always #5 clk = ~clk;

    hello_world_button_pio #(
        .WIDTH(W),
        .EDGE_TYPE(1),
        .IN_RESET_VAL(4'hF),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .read_n(read_n),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = v;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        v          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic test_reset();
        in_port = 4'hF;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_irq: got %b want 0", irq);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata: got %h want 0", readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'hF);
        bus_read(2'd0, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rst_data: got %h want %h", d, e);
        end
        exp_q.push_back(32'h0);
        bus_read(2'd2, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rst_mask: got %h want %h", d, e);
        end
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rst_edge: got %h want %h", d, e);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_irq2: got %b want 0", irq);
        end
    endtask

    // Reading EDGE_CAPTURE every cycle pins down the exact capture edge.
    task automatic test_fall_capture();
        @(negedge clk);
        in_port[2] = 1'b0;
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 2'd3;
        for (int k = 1; k <= LAT + 1; k++) begin
            exp_q.push_back((k > LAT) ? 32'h4 : 32'h0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL fall_lat k=%0d: got %h want %h",
                         k, readdata, e);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL fall_irq k=%0d: got %b want 0", k, irq);
            end
        end
        chipselect = 1'b0;
        read_n     = 1'b1;
        exp_q.push_back(32'hB);
        bus_read(2'd0, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL fall_data: got %h want %h", d, e);
        end
    endtask

    task automatic test_mask_irq();
        bus_write(2'd2, 32'h4);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_irq_on: got %b want 1", irq);
        end
        exp_q.push_back(32'h4);
        bus_read(2'd2, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL mask_rd: got %h want %h", d, e);
        end
        bus_write(2'd3, 32'h0);
        exp_q.push_back(32'h4);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e || irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_zero: got %h/%b want %h/1", d, irq, e);
        end
        bus_write(2'd3, 32'h4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_off: got %b want 0", irq);
        end
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL w1c_clear: got %h want %h", d, e);
        end
    endtask

    // The clear is sampled on the same edge that captures bit 0.
    task automatic test_collision();
        @(negedge clk);
        in_port[0] = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_q.push_back(32'h1);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL collision: got %h want %h", d, e);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL coll_irq: got %b want 0", irq);
        end
        bus_write(2'd3, 32'h1);
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL coll_clear: got %h want %h", d, e);
        end
    endtask

    task automatic test_rise_ignored();
        @(negedge clk);
        in_port = 4'hF;
        repeat (LAT + 3) @(negedge clk);
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rise_ign: got %h want %h", d, e);
        end
    endtask

    task automatic test_no_side_effects();
        @(negedge clk);
        in_port[2] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        bus_write(2'd0, 32'hFFFF_FFFF);
        exp_q.push_back(32'hB);
        bus_read(2'd0, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL data_ro: got %h want %h", d, e);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        bus_read(2'd1, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rsvd: got %h want %h", d, e);
        end
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 2'd3;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL b2b_rd%0d: got %h want %h",
                         k, readdata, e);
            end
        end
        chipselect = 1'b0;
        read_n     = 1'b1;
        bus_write(2'd2, 32'hFFFF_FFFF);
        exp_q.push_back(32'hF);
        bus_read(2'd2, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL mask_upper: got %h want %h", d, e);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_all_irq: got %b want 1", irq);
        end
    endtask

    task automatic test_reset_midop();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        in_port = 4'hF;
        #1;
        checks++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: got %b/%h want 0/0",
                     irq, readdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL midrst_edge: got %h want %h", d, e);
        end
        exp_q.push_back(32'h0);
        bus_read(2'd2, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL midrst_mask: got %h want %h", d, e);
        end
    endtask

`ifdef HELLO_BTN_DEBOUNCE_EN
    task automatic test_debounce();
        @(negedge clk);
        in_port[0] = 1'b0;
        repeat (10) @(negedge clk);
        in_port[0] = 1'b1;
        repeat (30) @(negedge clk);
        exp_q.push_back(32'h0);
        bus_read(2'd3, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL db_glitch: got %h want %h", d, e);
        end
        @(negedge clk);
        in_port[0] = 1'b0;
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 2'd3;
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back((k > 19) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL db_lat k=%0d: got %h want %h",
                         k, readdata, e);
            end
        end
        chipselect = 1'b0;
        read_n     = 1'b1;
        @(negedge clk);
        in_port[0] = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_fall_capture();
        test_mask_irq();
        test_collision();
        test_rise_ignored();
        test_no_side_effects();
        test_reset_midop();
`ifdef HELLO_BTN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
